uart_regs_v2: RTL and testbench

//   Second-generation memory-mapped register bank for the UART. Sits between the

---
 rtl/uart_regs_v2.sv | 278 +++++++++++++++++++++++++++
 tb/tb_uart_regs_v2.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_regs_v2.sv
// uart_regs_v2: second-generation UART MMIO register bank.
// Optional ERRCNT at address 8 is built when UART_REGS_ERRCNT_EN is defined.
module uart_regs_v2 #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_AW    = 4,
    parameter int BAUD_W     = 16,
    parameter int BAUD_RESET = 27
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           addr,
    input  logic [31:0]          wdata,
    input  logic [3:0]           wstrb,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [31:0]          rdata,
    output logic                 rvalid,
    output logic [DATA_BITS-1:0] tx_fifo_wdata,
    output logic                 tx_fifo_write,
    input  logic                 tx_fifo_full,
    input  logic [DATA_BITS-1:0] rx_fifo_rdata,
    output logic                 rx_fifo_read,
    input  logic                 rx_fifo_empty,
    input  logic [FIFO_AW:0]     tx_level,
    input  logic [FIFO_AW:0]     rx_level,
    output logic                 uart_en,
    output logic                 tx_fifo_reset,
    output logic                 rx_fifo_reset,
    output logic                 loopback_en,
    output logic [1:0]           parity_mode,
    output logic                 stop2,
    output logic [BAUD_W-1:0]    baud_div,
    input  logic                 rx_frame_err_p,
    input  logic                 rx_overrun_p,
    input  logic                 rx_parity_err_p,
    output logic                 irq
);

    localparam int LW = FIFO_AW + 1;

    localparam logic [3:0] A_CTRL   = 4'd0;
    localparam logic [3:0] A_STATUS = 4'd1;
    localparam logic [3:0] A_BAUD   = 4'd2;
    localparam logic [3:0] A_TXDATA = 4'd3;
    localparam logic [3:0] A_RXDATA = 4'd4;
    localparam logic [3:0] A_IER    = 4'd5;
    localparam logic [3:0] A_ISR    = 4'd6;
    localparam logic [3:0] A_THRESH = 4'd7;

    function automatic logic [31:0] bmerge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    // ctrl_q holds {stop2, parity[1:0], loopback, 2'b00, en}
    logic [6:0]           ctrl_q, ctrl_d;
    logic                 tx_rst_q, tx_rst_d;
    logic                 rx_rst_q, rx_rst_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [5:0]           ier_q, ier_d;
    logic [LW-1:0]        tx_th_q, tx_th_d;
    logic [LW-1:0]        rx_th_q, rx_th_d;
    // sticky ISR bits 5:2 = {TXDROP, PAR, FRM, OVR}
    logic [3:0]           isr_st_q, isr_st_d;
    logic                 tx_wr_q, tx_wr_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 rx_pop_q, rx_pop_d;
    logic                 rvalid_q, rvalid_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 irq_q, irq_d;

    logic [5:0]           isr_view;
    logic [31:0]          baud_view;
    logic [31:0]          thresh_view;
    logic [31:0]          status_view;
    logic [31:0]          th_new;
    logic [3:0]           isr_set;
    logic [3:0]           isr_clr;
    logic                 tx_drop;

`ifdef UART_REGS_ERRCNT_EN
    localparam logic [3:0] A_ERRCNT = 4'd8;

    logic [15:0] frm_cnt_q, frm_cnt_d;
    logic [15:0] ovr_cnt_q, ovr_cnt_d;
    logic        errcnt_clr;

    // Saturating error counters; a write to address 8 clears both
    always_comb begin
        errcnt_clr = wr_en && (addr == A_ERRCNT);
        frm_cnt_d  = frm_cnt_q;
        ovr_cnt_d  = ovr_cnt_q;
        if (errcnt_clr) begin
            frm_cnt_d = {15'd0, rx_frame_err_p};
            ovr_cnt_d = {15'd0, rx_overrun_p};
        end else begin
            if (rx_frame_err_p && (frm_cnt_q != 16'hFFFF)) begin
                frm_cnt_d = frm_cnt_q + 16'd1;
            end
            if (rx_overrun_p && (ovr_cnt_q != 16'hFFFF)) begin
                ovr_cnt_d = ovr_cnt_q + 16'd1;
            end
        end
    end

    // Error counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt_q <= '0;
            ovr_cnt_q <= '0;
        end else begin
            frm_cnt_q <= frm_cnt_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end
`endif

    // Live ISR view and read images of multi-field registers
    always_comb begin
        isr_view = {isr_st_q,
                    (rx_level >= rx_th_q) && !rx_fifo_empty,
                    (tx_level <= tx_th_q)};
        baud_view = 32'(baud_q);
        thresh_view = '0;
        thresh_view[FIFO_AW:0] = tx_th_q;
        thresh_view[16+FIFO_AW:16] = rx_th_q;
        status_view = {8'(rx_level), 8'(tx_level), 8'h00,
                       isr_view, rx_fifo_empty, tx_fifo_full};
    end

    // Write decode, read capture, sticky status and interrupt next-state
    always_comb begin
        ctrl_d    = ctrl_q;
        tx_rst_d  = 1'b0;
        rx_rst_d  = 1'b0;
        baud_d    = baud_q;
        ier_d     = ier_q;
        tx_th_d   = tx_th_q;
        rx_th_d   = rx_th_q;
        tx_wr_d   = 1'b0;
        tx_data_d = tx_data_q;
        rx_pop_d  = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        th_new    = '0;
        isr_clr   = '0;
        tx_drop   = 1'b0;

        if (wr_en) begin
            case (addr)
                A_CTRL: begin
                    if (wstrb[0]) begin
                        ctrl_d   = {wdata[6:3], 2'b00, wdata[0]};
                        tx_rst_d = wdata[1];
                        rx_rst_d = wdata[2];
                    end
                end
                A_BAUD: begin
                    baud_d = BAUD_W'(bmerge(baud_view, wdata, wstrb));
                end
                A_TXDATA: begin
                    if (wstrb[0]) begin
                        if (tx_fifo_full) begin
                            tx_drop = 1'b1;
                        end else begin
                            tx_wr_d   = 1'b1;
                            tx_data_d = wdata[DATA_BITS-1:0];
                        end
                    end
                end
                A_IER: begin
                    if (wstrb[0]) begin
                        ier_d = wdata[5:0];
                    end
                end
                A_ISR: begin
                    isr_clr = wdata[5:2];
                end
                A_THRESH: begin
                    th_new  = bmerge(thresh_view, wdata, wstrb);
                    tx_th_d = th_new[FIFO_AW:0];
                    rx_th_d = th_new[16+FIFO_AW:16];
                end
                default: begin
                end
            endcase
        end

        if (rd_en) begin
            rvalid_d = 1'b1;
            case (addr)
                A_CTRL:   rdata_d = {25'd0, ctrl_q};
                A_STATUS: rdata_d = status_view;
                A_BAUD:   rdata_d = baud_view;
                A_RXDATA: begin
                    if (rx_fifo_empty) begin
                        rdata_d = 32'h8000_0000;
                    end else begin
                        rdata_d  = 32'(rx_fifo_rdata);
                        rx_pop_d = 1'b1;
                    end
                end
                A_IER:    rdata_d = {26'd0, ier_q};
                A_ISR:    rdata_d = {26'd0, isr_view};
                A_THRESH: rdata_d = thresh_view;
`ifdef UART_REGS_ERRCNT_EN
                A_ERRCNT: rdata_d = {ovr_cnt_q, frm_cnt_q};
`endif
                default:  rdata_d = '0;
            endcase
        end

        // events beat a simultaneous W1C clear
        isr_set  = {tx_drop, rx_parity_err_p, rx_frame_err_p, rx_overrun_p};
        isr_st_d = (isr_st_q & ~isr_clr) | isr_set;
        irq_d    = |(isr_view & ier_q);
    end

    // State registers; FIFO resets held high through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            tx_rst_q  <= 1'b1;
            rx_rst_q  <= 1'b1;
            baud_q    <= BAUD_W'(BAUD_RESET);
            ier_q     <= '0;
            tx_th_q   <= LW'(1);
            rx_th_q   <= LW'(1);
            isr_st_q  <= '0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= '0;
            rx_pop_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            tx_rst_q  <= tx_rst_d;
            rx_rst_q  <= rx_rst_d;
            baud_q    <= baud_d;
            ier_q     <= ier_d;
            tx_th_q   <= tx_th_d;
            rx_th_q   <= rx_th_d;
            isr_st_q  <= isr_st_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
            rx_pop_q  <= rx_pop_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^wdata;

    assign rdata         = rdata_q;
    assign rvalid        = rvalid_q;
    assign tx_fifo_wdata = tx_data_q;
    assign tx_fifo_write = tx_wr_q;
    assign rx_fifo_read  = rx_pop_q;
    assign uart_en       = ctrl_q[0];
    assign tx_fifo_reset = tx_rst_q;
    assign rx_fifo_reset = rx_rst_q;
    assign loopback_en   = ctrl_q[3];
    assign parity_mode   = ctrl_q[5:4];
    assign stop2         = ctrl_q[6];
    assign baud_div      = baud_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_uart_regs_v2.sv
// tb_uart_regs_v2: directed self-checking bench for uart_regs_v2.
// Define UART_REGS_ERRCNT_EN to also exercise the error counters.
module tb_uart_regs_v2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rdata;
    logic        rvalid;
    logic [7:0]  tx_fifo_wdata;
    logic        tx_fifo_write;
    logic        tx_fifo_full;
    logic [7:0]  rx_fifo_rdata;
    logic        rx_fifo_read;
    logic        rx_fifo_empty;
    logic [4:0]  tx_level;
    logic [4:0]  rx_level;
    logic        uart_en;
    logic        tx_fifo_reset;
    logic        rx_fifo_reset;
    logic        loopback_en;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic [15:0] baud_div;
    logic        rx_frame_err_p;
    logic        rx_overrun_p;
    logic        rx_parity_err_p;
    logic        irq;

    int n_pass = 0;
    int n_tot  = 0;

    logic [31:0] rd_d;
    logic        rd_v;

    uart_regs_v2 dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .wr_en(wr_en), .rd_en(rd_en),
        .rdata(rdata), .rvalid(rvalid),
        .tx_fifo_wdata(tx_fifo_wdata), .tx_fifo_write(tx_fifo_write),
        .tx_fifo_full(tx_fifo_full), .rx_fifo_rdata(rx_fifo_rdata),
        .rx_fifo_read(rx_fifo_read), .rx_fifo_empty(rx_fifo_empty),
        .tx_level(tx_level), .rx_level(rx_level),
        .uart_en(uart_en), .tx_fifo_reset(tx_fifo_reset),
        .rx_fifo_reset(rx_fifo_reset), .loopback_en(loopback_en),
        .parity_mode(parity_mode), .stop2(stop2), .baud_div(baud_div),
        .rx_frame_err_p(rx_frame_err_p), .rx_overrun_p(rx_overrun_p),
        .rx_parity_err_p(rx_parity_err_p), .irq(irq)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        @(negedge clk);
        addr = a; wdata = d; wstrb = s; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d,
                      output logic v);
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rdata;
        v = rvalid;
    endtask

    initial begin
        rst_n = 1'b1;
        addr = '0; wdata = '0; wstrb = '0; wr_en = 1'b0; rd_en = 1'b0;
        tx_fifo_full = 1'b0; rx_fifo_rdata = '0; rx_fifo_empty = 1'b1;
        tx_level = '0; rx_level = '0;
        rx_frame_err_p = 1'b0; rx_overrun_p = 1'b0; rx_parity_err_p = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_txrst", 32'(tx_fifo_reset), 32'd1);
        chk("rst_rxrst", 32'(rx_fifo_reset), 32'd1);
        chk("rst_baud", 32'(baud_div), 32'd27);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_ctrl", {uart_en, loopback_en, parity_mode, stop2}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_txrst_hi", 32'(tx_fifo_reset), 32'd1);
        @(negedge clk);
        chk("rel_resets_lo", {tx_fifo_reset, rx_fifo_reset}, 32'd0);

        rd(4'd2, rd_d, rd_v);
        chk("baud_rvalid", 32'(rd_v), 32'd1);
        chk("baud_rdata", rd_d, 32'h1B);
        @(negedge clk);
        chk("rvalid_pulse", 32'(rvalid), 32'd0);
        chk("rdata_hold", rdata, 32'h1B);

        wr(4'd2, 32'h1234_5678, 4'b0001);
        chk("baud_b0", 32'(baud_div), 32'h0078);
        wr(4'd2, 32'h1234_5678, 4'b1111);
        chk("baud_full", 32'(baud_div), 32'h5678);

        wr(4'd0, 32'h7F, 4'b0001);
        chk("ctrl_pulse", {tx_fifo_reset, rx_fifo_reset}, 32'd3);
        chk("ctrl_fields", {uart_en, loopback_en, parity_mode, stop2},
            32'h1F);
        @(negedge clk);
        chk("ctrl_pulse_end", {tx_fifo_reset, rx_fifo_reset}, 32'd0);
        rd(4'd0, rd_d, rd_v);
        chk("ctrl_rd", rd_d, 32'h79);
        wr(4'd0, 32'h0000_0006, 4'b0010);
        chk("ctrl_nostrb", {tx_fifo_reset, rx_fifo_reset, uart_en},
            32'd1);

        tx_level = 5'd5;
        tx_fifo_full = 1'b1;
        wr(4'd3, 32'h41, 4'b0001);
        chk("txdrop_nowr", 32'(tx_fifo_write), 32'd0);
        rd(4'd6, rd_d, rd_v);
        chk("isr_txdrop", rd_d, 32'h20);
        wr(4'd6, 32'h20, 4'b0001);
        rd(4'd6, rd_d, rd_v);
        chk("isr_w1c", rd_d, 32'h00);
        tx_fifo_full = 1'b0;
        wr(4'd3, 32'h1C3, 4'b0001);
        chk("tx_push", {tx_fifo_write, tx_fifo_wdata}, 32'h1C3);
        @(negedge clk);
        chk("tx_push_end", 32'(tx_fifo_write), 32'd0);

        rx_fifo_empty = 1'b0; rx_fifo_rdata = 8'h5A; rx_level = 5'd1;
        rd(4'd4, rd_d, rd_v);
        chk("rx_data", rd_d, 32'h5A);
        chk("rx_pop", 32'(rx_fifo_read), 32'd1);
        @(negedge clk);
        chk("rx_pop_end", 32'(rx_fifo_read), 32'd0);
        rx_fifo_empty = 1'b1; rx_level = 5'd0;
        rd(4'd4, rd_d, rd_v);
        chk("rx_empty", rd_d, 32'h8000_0000);
        chk("rx_nopop", 32'(rx_fifo_read), 32'd0);

        tx_fifo_full = 1'b1; rx_fifo_empty = 1'b0; rx_level = 5'd3;
        rd(4'd1, rd_d, rd_v);
        chk("status", rd_d, 32'h0305_0009);
        tx_fifo_full = 1'b0;
        wr(4'd7, 32'h0003_0007, 4'b1111);
        rd(4'd7, rd_d, rd_v);
        chk("thresh", rd_d, 32'h0003_0007);
        rd(4'd6, rd_d, rd_v);
        chk("isr_live", rd_d, 32'h03);
        wr(4'd7, 32'hFFFF_FFFF, 4'b0001);
        rd(4'd7, rd_d, rd_v);
        chk("thresh_b0", rd_d, 32'h0003_001F);
        rx_fifo_empty = 1'b1; rx_level = 5'd0;

        wr(4'd5, 32'h04, 4'b0001);
        @(negedge clk);
        rx_overrun_p = 1'b1;
        @(negedge clk);
        rx_overrun_p = 1'b0;
        chk("irq_lat1", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_lat2", 32'(irq), 32'd1);
        @(negedge clk);
        addr = 4'd6; wdata = 32'h04; wstrb = 4'b0001; wr_en = 1'b1;
        rx_overrun_p = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; rx_overrun_p = 1'b0;
        rd(4'd6, rd_d, rd_v);
        chk("w1c_vs_event", rd_d, 32'h05);
        wr(4'd6, 32'h04, 4'b0001);
        rd(4'd6, rd_d, rd_v);
        chk("w1c_ovr", rd_d, 32'h01);
        chk("irq_clear", 32'(irq), 32'd0);

        @(negedge clk);
        addr = 4'd5; wdata = 32'h3F; wstrb = 4'b1111;
        wr_en = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rw_prewrite", rdata, 32'h04);
        rd(4'd5, rd_d, rd_v);
        chk("rw_postwrite", rd_d, 32'h3F);
        chk("irq_txlow", 32'(irq), 32'd1);
        wr(4'd5, 32'h00, 4'b0001);

        @(negedge clk);
        rx_frame_err_p = 1'b1;
        @(negedge clk);
        rx_frame_err_p = 1'b0;
        rd(4'd6, rd_d, rd_v);
        chk("isr_frm", rd_d, 32'h09);
        wr(4'd6, 32'h3F, 4'b0001);
        rd(4'd6, rd_d, rd_v);
        chk("isr_clr_all", rd_d, 32'h01);

`ifdef UART_REGS_ERRCNT_EN
        wr(4'd8, 32'h0, 4'b1111);
        @(negedge clk);
        rx_frame_err_p = 1'b1;
        repeat (3) @(negedge clk);
        rx_frame_err_p = 1'b0;
        rd(4'd8, rd_d, rd_v);
        chk("errcnt_3", rd_d, 32'h0000_0003);
        rx_overrun_p = 1'b1;
        repeat (2) @(negedge clk);
        rx_overrun_p = 1'b0;
        rd(4'd8, rd_d, rd_v);
        chk("errcnt_ovr", rd_d, 32'h0002_0003);
        wr(4'd8, 32'h0, 4'b0000);
        rd(4'd8, rd_d, rd_v);
        chk("errcnt_clr", rd_d, 32'h0);
        @(negedge clk);
        addr = 4'd8; wr_en = 1'b1; rx_frame_err_p = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; rx_frame_err_p = 1'b0;
        rd(4'd8, rd_d, rd_v);
        chk("errcnt_clr_evt", rd_d, 32'h0000_0001);
        rx_frame_err_p = 1'b1;
        repeat (70000) @(negedge clk);
        rx_frame_err_p = 1'b0;
        rd(4'd8, rd_d, rd_v);
        chk("errcnt_sat", rd_d, 32'h0000_FFFF);
`else
        wr(4'd8, 32'hFFFF_FFFF, 4'b1111);
        rd(4'd8, rd_d, rd_v);
        chk("addr8_zero", rd_d, 32'h0);
`endif

        @(negedge clk);
        rx_fifo_empty = 1'b0; rx_fifo_rdata = 8'h33;
        addr = 4'd4; rd_en = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk("abort_rvalid", 32'(rvalid), 32'd0);
        chk("abort_pop", 32'(rx_fifo_read), 32'd0);
        chk("abort_baud", 32'(baud_div), 32'd27);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
